branch_pc_sequencer: RTL

Program-counter sequencer for the 64-bit LEGv8 core. Owns the PC register, decodes the unconditional, compare-and-branch and conditional-branch formats, and sign-extends their 26- and 19-bit offsets internally. Resolves each branch in a two-state FSM and presents the next fetch address to instruction memory. Sits between instruction memory and the decode stage, and drives a redirect pulse to flush younger work.

---
 rtl/branch_pc_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/branch_pc_sequencer.sv
// rtl/branch_pc_sequencer.sv - LEGv8 PC sequencer with two-state branch resolution
// Decodes B / CBZ / CBNZ / B.cond in RUN and applies the latched decision in RESOLVE.
module branch_pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             rt_zero,
  input  logic [3:0]       flags,
  output logic [63:0]      pc,
  output logic             busy,
  output logic             redirect,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {RUN, RESOLVE} state_t;

  state_t             state_q, state_d;
  logic [63:0]        pc_q, pc_d;
  logic [63:0]        br_pc_q, br_pc_d;
  logic [63:0]        br_off_q, br_off_d;
  logic               br_taken_q, br_taken_d;
  logic               redirect_q, redirect_d;
  logic [CNT_W-1:0]   taken_count_q, taken_count_d;

  logic               is_b, is_cbz, is_cbnz, is_bcond, is_branch;
  logic               cond_true, decision;
  logic [63:0]        off26, off19, offset;
  logic               f_n, f_z, f_c, f_v;
  logic               unused_instr_bit;

  // Bit 4 belongs to the Rt field, which is resolved outside this block via rt_zero.
  assign unused_instr_bit = instr[4];

  assign {f_n, f_z, f_c, f_v} = flags;

  assign is_b      = (instr[31:26] == 6'b000101);
  assign is_cbz    = (instr[31:24] == 8'b10110100);
  assign is_cbnz   = (instr[31:24] == 8'b10110101);
  assign is_bcond  = (instr[31:24] == 8'b01010100);
  assign is_branch = is_b | is_cbz | is_cbnz | is_bcond;

  assign off26  = {{36{instr[25]}}, instr[25:0], 2'b00};
  assign off19  = {{43{instr[23]}}, instr[23:5], 2'b00};
  assign offset = is_b ? off26 : off19;

  always_comb begin
    cond_true = 1'b0;
    case (instr[3:0])
      4'b0000: cond_true = f_z;
      4'b0001: cond_true = !f_z;
      4'b0010: cond_true = f_c;
      4'b0011: cond_true = !f_c;
      4'b0100: cond_true = f_n;
      4'b0101: cond_true = !f_n;
      4'b0110: cond_true = f_v;
      4'b0111: cond_true = !f_v;
      4'b1000: cond_true = f_c & !f_z;
      4'b1001: cond_true = !(f_c & !f_z);
      4'b1010: cond_true = (f_n == f_v);
      4'b1011: cond_true = (f_n != f_v);
      4'b1100: cond_true = !f_z & (f_n == f_v);
      4'b1101: cond_true = !(!f_z & (f_n == f_v));
      default: cond_true = 1'b1;
    endcase
  end

  always_comb begin
    decision = 1'b0;
    if (is_b)          decision = 1'b1;
    else if (is_cbz)   decision = rt_zero;
    else if (is_cbnz)  decision = !rt_zero;
    else if (is_bcond) decision = cond_true;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    br_pc_d       = br_pc_q;
    br_off_d      = br_off_q;
    br_taken_d    = br_taken_q;
    redirect_d    = 1'b0;
    taken_count_d = taken_count_q;
    case (state_q)
      RUN: begin
        if (!stall && instr_valid) begin
          if (is_branch) begin
            br_pc_d    = pc_q;
            br_off_d   = offset;
            br_taken_d = decision;
            state_d    = RESOLVE;
          end else begin
            pc_d = pc_q + 64'd4;
          end
        end
      end
      RESOLVE: begin
        if (!stall) begin
          pc_d       = br_taken_q ? (br_pc_q + br_off_q) : (br_pc_q + 64'd4);
          redirect_d = br_taken_q;
          if (br_taken_q && (taken_count_q != {CNT_W{1'b1}}))
            taken_count_d = taken_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      br_pc_q       <= 64'h0;
      br_off_q      <= 64'h0;
      br_taken_q    <= 1'b0;
      redirect_q    <= 1'b0;
      taken_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      br_pc_q       <= br_pc_d;
      br_off_q      <= br_off_d;
      br_taken_q    <= br_taken_d;
      redirect_q    <= redirect_d;
      taken_count_q <= taken_count_d;
    end
  end

  assign pc          = pc_q;
  assign busy        = (state_q == RESOLVE);
  assign redirect    = redirect_q;
  assign taken_count = taken_count_q;

endmodule
